imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Receives a program as a byte stream and writes it into instruction memory.
// The stream is N little-endian words followed by one checksum byte, which must
// equal the XOR of all payload bytes. The processor is held in reset while the
// loader is busy.
//
// Parameters
//   INS_ADDRESS : instruction-memory byte-address width
//   INS_W       : instruction word width (four bytes per word)
//
// Ports
//   clk, rst    : clock (rising edge) and asynchronous active-high reset
//   start       : one-cycle load request. Accepted only when idle or done.
//   load_words  : requested word count. Captured on an accepted start and
//                 clamped to the memory depth.
//   byte_valid  : byte_data carries a byte
//   byte_data   : program byte
//   byte_ready  : loader accepts a byte this cycle
//   we, wa, wd  : instruction-memory write strobe, byte address and data
//   cpu_hold    : hold the processor while loading
//   done        : load finished; stays high until the next accepted start
//   err         : checksum mismatch on the last load
// -----------------------------------------------------------------------------
module imem_loader #(
    parameter int INS_ADDRESS = 9,
    parameter int INS_W       = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [INS_ADDRESS-2:0] load_words,
    input  logic                   byte_valid,
    input  logic [7:0]             byte_data,
    output logic                   byte_ready,
    output logic                   we,
    output logic [INS_ADDRESS-1:0] wa,
    output logic [INS_W-1:0]       wd,
    output logic                   cpu_hold,
    output logic                   done,
    output logic                   err
);

    localparam int BYTES  = INS_W / 8;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int IDX_W  = INS_ADDRESS - 1;   // wide enough to hold the word count itself
    localparam int SLOT_W = INS_ADDRESS - 2;   // word-index field of the byte address
    localparam logic [IDX_W-1:0] MAX_WORDS = IDX_W'(1) << SLOT_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   n_reg;
    logic [IDX_W-1:0]   word_idx_reg;
    logic [CNT_W-1:0]   byte_cnt_reg;
    logic [7:0]         csum_reg;
    logic               we_reg;
    logic [INS_ADDRESS-1:0] wa_reg;
    logic [INS_W-1:0]   wd_reg;
    logic               err_reg;
    logic [7:0]         lane_reg [BYTES-1];   // lower bytes of the word being assembled

    logic               busy;
    logic               accept;
    logic               start_accept;
    logic               load_accept;
    logic               check_accept;
    logic               last_byte;
    logic               last_word;
    logic [IDX_W-1:0]   n_clamped;
    logic [INS_W-1:0]   word_full;

    // ---------------------------------------------------------------------
    // Handshake and decode
    // ---------------------------------------------------------------------
    assign busy         = (state_reg == LOAD) || (state_reg == CHECK);
    assign accept       = byte_valid && busy;
    assign start_accept = start && ((state_reg == IDLE) || (state_reg == DONE));
    assign load_accept  = accept && (state_reg == LOAD);
    assign check_accept = accept && (state_reg == CHECK);
    assign last_byte    = (byte_cnt_reg == CNT_W'(BYTES - 1));
    assign last_word    = ((word_idx_reg + IDX_W'(1)) == n_reg);

    // Clamping the count keeps the address index from ever wrapping.
    assign n_clamped = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;

    // ---------------------------------------------------------------------
    // Byte lanes: lane gi captures the gi-th byte of a word. The top byte is
    // never stored; it is taken straight from the input on the final edge.
    // ---------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < BYTES - 1; gi++) begin : g_lane
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lane_reg[gi] <= 8'h00;
                end else if (load_accept && (byte_cnt_reg == CNT_W'(gi))) begin
                    lane_reg[gi] <= byte_data;
                end
            end
            assign word_full[gi*8 +: 8] = lane_reg[gi];
        end
    endgenerate
    assign word_full[INS_W-1 -: 8] = byte_data;

    // ---------------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        byte_ready = 1'b0;
        cpu_hold   = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                done = (state_reg == DONE);
                if (start) begin
                    state_next = (n_clamped == '0) ? CHECK : LOAD;
                end
            end
            LOAD: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (load_accept && last_byte && last_word) begin
                    state_next = CHECK;
                end
            end
            CHECK: begin
                byte_ready = 1'b1;
                cpu_hold   = 1'b1;
                if (check_accept) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath: counters, checksum and the registered write port
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_reg        <= '0;
            word_idx_reg <= '0;
            byte_cnt_reg <= '0;
            csum_reg     <= 8'h00;
            we_reg       <= 1'b0;
            wa_reg       <= '0;
            wd_reg       <= '0;
            err_reg      <= 1'b0;
        end else begin
            // The strobe is a single-cycle pulse; address and data hold.
            we_reg <= 1'b0;
            if (start_accept) begin
                n_reg        <= n_clamped;
                word_idx_reg <= '0;
                byte_cnt_reg <= '0;
                csum_reg     <= 8'h00;
                err_reg      <= 1'b0;
            end else if (load_accept) begin
                csum_reg <= csum_reg ^ byte_data;
                if (last_byte) begin
                    byte_cnt_reg <= '0;
                    we_reg       <= 1'b1;
                    wd_reg       <= word_full;
                    wa_reg       <= {word_idx_reg[SLOT_W-1:0], 2'b00};
                    word_idx_reg <= word_idx_reg + IDX_W'(1);
                end else begin
                    byte_cnt_reg <= byte_cnt_reg + CNT_W'(1);
                end
            end else if (check_accept) begin
                err_reg <= (byte_data != csum_reg);
            end
        end
    end

    assign we  = we_reg;
    assign wa  = wa_reg;
    assign wd  = wd_reg;
    assign err = err_reg;

endmodule
